// File: rtl/shift_delay_checker.sv
// Receive-side monitor for a shift-register delay line: times each din transition
// until it appears on dout (in enabled cycles) and checks it against DEPTH.
module shift_delay_checker #(
  parameter int DEPTH   = 100,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             din,
  input  logic             dout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] measured_delay,
  output logic             err_timeout,
  output logic             err_overrun,
  output logic             err_mismatch,
  output logic [7:0]       meas_count
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             din_prev_q, din_prev_d;
  logic             pol_q, pol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] measured_delay_q, measured_delay_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_overrun_q, err_overrun_d;
  logic             err_mismatch_q, err_mismatch_d;
  logic [7:0]       meas_count_q, meas_count_d;

  logic [CNT_W-1:0] cnt_n;
  logic [7:0]       meas_count_inc;
  logic             depth_ok;

  always_comb begin
    state_d          = state_q;
    din_prev_d       = din_prev_q;
    pol_d            = pol_q;
    cnt_d            = cnt_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = 1'b0;
    measured_delay_d = measured_delay_q;
    err_timeout_d    = err_timeout_q;
    err_overrun_d    = err_overrun_q;
    err_mismatch_d   = err_mismatch_q;
    meas_count_d     = meas_count_q;

    cnt_n          = cnt_q + CNT_W'(1);
    depth_ok       = (cnt_n == DEPTH_C);
    meas_count_inc = (meas_count_q == 8'hFF) ? meas_count_q : meas_count_q + 8'd1;

    if (enable) begin
      din_prev_d = din;
      unique case (state_q)
        IDLE: begin
          if (din != din_prev_q) begin
            pol_d   = din;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // A second transition is only flagged; timing stays locked to pol_q.
          if (din != din_prev_q) begin
            err_overrun_d = 1'b1;
          end
          if (dout == pol_q) begin
            measured_delay_d = cnt_n;
            done_d           = 1'b1;
            pass_d           = depth_ok;
            meas_count_d     = meas_count_inc;
            err_mismatch_d   = err_mismatch_q | ~depth_ok;
            busy_d           = 1'b0;
            state_d          = IDLE;
          end else if (cnt_n == TIMEOUT_C) begin
            measured_delay_d = TIMEOUT_C;
            done_d           = 1'b1;
            pass_d           = 1'b0;
            err_timeout_d    = 1'b1;
            err_mismatch_d   = 1'b1;
            meas_count_d     = meas_count_inc;
            busy_d           = 1'b0;
            state_d          = IDLE;
          end else begin
            cnt_d = cnt_n;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      din_prev_q       <= 1'b0;
      pol_q            <= 1'b0;
      cnt_q            <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      measured_delay_q <= '0;
      err_timeout_q    <= 1'b0;
      err_overrun_q    <= 1'b0;
      err_mismatch_q   <= 1'b0;
      meas_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      din_prev_q       <= din_prev_d;
      pol_q            <= pol_d;
      cnt_q            <= cnt_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      measured_delay_q <= measured_delay_d;
      err_timeout_q    <= err_timeout_d;
      err_overrun_q    <= err_overrun_d;
      err_mismatch_q   <= err_mismatch_d;
      meas_count_q     <= meas_count_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign measured_delay = measured_delay_q;
  assign err_timeout    = err_timeout_q;
  assign err_overrun    = err_overrun_q;
  assign err_mismatch   = err_mismatch_q;
  assign meas_count     = meas_count_q;

endmodule

// File: tb/tb_shift_delay_checker.sv
// Directed bench for shift_delay_checker: drives a behavioural delay line whose tap
// selects 16 stages, 17 stages or a stuck-at-0 output.
module tb_shift_delay_checker;

  localparam int DEPTH   = 16;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 40;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             din;
  logic             dout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] measured_delay;
  logic             err_timeout;
  logic             err_overrun;
  logic             err_mismatch;
  logic [7:0]       meas_count;

  logic [16:0] line_q;
  int          tap_mode;
  int          compared   = 0;
  int          mismatched = 0;
  int          bc;
  int          activity;

  always #5 clk = ~clk;

  // Delay line under observation; the tap picks its effective length.
  always @(posedge clk) begin
    if (reset)       line_q <= '0;
    else if (enable) line_q <= {line_q[15:0], din};
  end

  assign dout = (tap_mode == 0) ? line_q[15] :
                (tap_mode == 1) ? line_q[16] : 1'b0;

  shift_delay_checker #(
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .din           (din),
    .dout          (dout),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .measured_delay(measured_delay),
    .err_timeout   (err_timeout),
    .err_overrun   (err_overrun),
    .err_mismatch  (err_mismatch),
    .meas_count    (meas_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic d);
    enable = en;
    din    = d;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic check_status(input string tag, input int e_busy, input int e_done,
                              input int e_pass, input int e_md, input int e_to,
                              input int e_ov, input int e_mm, input int e_cnt);
    checkOutput({tag, ".busy"},           32'(busy),           32'(e_busy));
    checkOutput({tag, ".done"},           32'(done),           32'(e_done));
    checkOutput({tag, ".pass"},           32'(pass),           32'(e_pass));
    checkOutput({tag, ".measured_delay"}, 32'(measured_delay), 32'(e_md));
    checkOutput({tag, ".err_timeout"},    32'(err_timeout),    32'(e_to));
    checkOutput({tag, ".err_overrun"},    32'(err_overrun),    32'(e_ov));
    checkOutput({tag, ".err_mismatch"},   32'(err_mismatch),   32'(e_mm));
    checkOutput({tag, ".meas_count"},     32'(meas_count),     32'(e_cnt));
  endtask

  // Ticks until done, optionally toggling enable every cycle and flipping din once.
  task automatic wait_done(input string tag, input int max_ticks, input bit gap,
                           input int flip_at, output int busy_cycles);
    bit seen = 1'b0;
    busy_cycles = 0;
    for (int n = 1; n <= max_ticks && !seen; n++) begin
      tick();
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
      if (!seen) begin
        if (n == flip_at) din = ~din;
        if (gap) enable = ~enable;
      end
    end
    checkOutput({tag, ".done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    tap_mode = 0;
    do_reset(10);
    check_status("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("idle.busy", 32'(busy), 32'd0);
    din = 1'b1;
    wait_done("match", 60, 1'b0, 0, bc);
    checkOutput("match.busy_cycles", 32'(bc), 32'd16);
    check_status("match", 0, 1, 1, 16, 0, 0, 0, 1);
    tick();
    check_status("match.after", 0, 0, 0, 16, 0, 0, 0, 1);

    repeat (4) tick();
    applyStimulus(1'b1, 1'b0);
    wait_done("gap", 80, 1'b1, 0, bc);
    checkOutput("gap.busy_cycles", 32'(bc), 32'd32);
    check_status("gap", 0, 1, 1, 16, 0, 0, 0, 2);
    enable = 1'b0;
    tick();
    check_status("gap.after", 0, 0, 0, 16, 0, 0, 0, 2);

    do_reset(2);
    tap_mode = 1;
    applyStimulus(1'b1, 1'b0);
    repeat (3) tick();
    din = 1'b1;
    wait_done("rise17", 60, 1'b0, 0, bc);
    check_status("rise17", 0, 1, 0, 17, 0, 0, 1, 1);
    repeat (20) tick();
    din = 1'b0;
    wait_done("fall17", 60, 1'b0, 0, bc);
    check_status("fall17", 0, 1, 0, 17, 0, 0, 1, 2);

    do_reset(2);
    tap_mode = 2;
    applyStimulus(1'b1, 1'b0);
    repeat (3) tick();
    din = 1'b1;
    wait_done("timeout", 60, 1'b0, 0, bc);
    checkOutput("timeout.busy_cycles", 32'(bc), 32'd40);
    check_status("timeout", 0, 1, 0, 40, 1, 0, 1, 1);
    tap_mode = 0;
    repeat (5) tick();
    check_status("idle_dout", 0, 0, 0, 40, 1, 0, 1, 1);

    do_reset(2);
    tap_mode = 0;
    applyStimulus(1'b1, 1'b0);
    repeat (3) tick();
    din = 1'b1;
    wait_done("overrun", 60, 1'b0, 5, bc);
    checkOutput("overrun.busy_cycles", 32'(bc), 32'd16);
    check_status("overrun", 0, 1, 1, 16, 0, 1, 0, 1);
    activity = 0;
    repeat (30) begin
      tick();
      if (busy || done) activity++;
    end
    checkOutput("overrun.quiet", 32'(activity), 32'd0);
    checkOutput("overrun.meas_count", 32'(meas_count), 32'd1);

    din = 1'b1;
    repeat (9) tick();
    checkOutput("midreset.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_status("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
    wait_done("post_reset", 60, 1'b0, 0, bc);
    check_status("post_reset", 0, 1, 1, 16, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
